// File: rtl/bus_bridge_if.sv
// -----------------------------------------------------------------------------
// bus_bridge_if
// Groups the CPU-side request signals and the slave-side bus of bus_bridge.
//
// CPU side : mod, eff_addr, cpu_re, cpu_we, cpu_wdata   -> bridge
//            cpu_rdata, cpu_stall, bus_err               <- bridge
// Slave side: slv_sel, slv_addr, slv_wdata, slv_re, slv_we <- bridge
//             slv_ack[15:0], slv_rdata[511:0]              -> bridge
//             (slave n drives slv_rdata[32n+31:32n])
//
// Modports:
//   master - the bridge itself (bus master towards the slaves)
//   slave  - the environment: CPU/decoder and the slave modules
// -----------------------------------------------------------------------------
interface bus_bridge_if;
  logic [7:0]   mod;
  logic [31:0]  eff_addr;
  logic         cpu_re;
  logic         cpu_we;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_stall;
  logic         bus_err;
  logic [15:0]  slv_sel;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic         slv_re;
  logic         slv_we;
  logic [15:0]  slv_ack;
  logic [511:0] slv_rdata;

  modport master (
    input  mod, eff_addr, cpu_re, cpu_we, cpu_wdata, slv_ack, slv_rdata,
    output cpu_rdata, cpu_stall, bus_err, slv_sel, slv_addr, slv_wdata,
           slv_re, slv_we
  );

  modport slave (
    output mod, eff_addr, cpu_re, cpu_we, cpu_wdata, slv_ack, slv_rdata,
    input  cpu_rdata, cpu_stall, bus_err, slv_sel, slv_addr, slv_wdata,
           slv_re, slv_we
  );
endinterface

// File: rtl/bus_bridge.sv
// -----------------------------------------------------------------------------
// bus_bridge
// Bridges single CPU read/write requests onto a 16-slot slave bus.
// IDLE latches the request, ACCESS issues a one-cycle strobe to the selected
// slave, WAIT holds the select until that slave acks, DONE returns data and
// releases the CPU stall for one cycle.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   rst  - asynchronous, active-low reset
//   bus  - bus_bridge_if.master (CPU request/response + slave bus)
//
// Parameter:
//   TIMEOUT - WAIT cycles without ack before abort (1-255), used only when
//             the timeout option is built in.
//
// Build option:
//   BUS_BRIDGE_TIMEOUT_EN - when defined, an 8-bit counter aborts a WAIT
//   that lasts TIMEOUT cycles, returning 32'hDEADBEEF with bus_err. When
//   undefined, WAIT lasts until the selected slave acks.
// -----------------------------------------------------------------------------
module bus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  bus_bridge_if.master  bus
);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_bridge: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t       state_reg;
  logic [3:0]   mod_reg;       // only valid (0-13) module numbers reach ACCESS
  logic         write_reg;
  logic [15:0]  sel_reg;
  logic [31:0]  addr_reg;
  logic [31:0]  wdata_reg;
  logic [31:0]  rdata_reg;
  logic         re_reg;
  logic         we_reg;
  logic         err_reg;

`ifdef BUS_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]   tmo_cnt_reg;
`endif

  logic         req;
  logic         ack_hit;
  logic [31:0]  rdata_slice [16];

  // Unflatten the slave read-data bus into one word per module.
  for (genvar gi = 0; gi < 16; gi++) begin : g_slice
    assign rdata_slice[gi] = bus.slv_rdata[gi*32 +: 32];
  end

  assign req     = bus.cpu_re | bus.cpu_we;
  // Only the latched module's ack counts; all other ack bits are ignored.
  assign ack_hit = bus.slv_ack[mod_reg];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      mod_reg     <= 4'd0;
      write_reg   <= 1'b0;
      sel_reg     <= 16'h0000;
      addr_reg    <= 32'h0;
      wdata_reg   <= 32'h0;
      rdata_reg   <= 32'h0;
      re_reg      <= 1'b0;
      we_reg      <= 1'b0;
      err_reg     <= 1'b0;
`ifdef BUS_BRIDGE_TIMEOUT_EN
      tmo_cnt_reg <= 8'd0;
`endif
    end else begin
      // Strobes and the error flag are single-cycle pulses.
      re_reg  <= 1'b0;
      we_reg  <= 1'b0;
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            mod_reg   <= bus.mod[3:0];
            addr_reg  <= bus.eff_addr;
            wdata_reg <= bus.cpu_wdata;
            write_reg <= bus.cpu_we;   // write wins when both are requested
            if (bus.mod <= 8'd13) begin
              sel_reg   <= 16'h0001 << bus.mod[3:0];
              we_reg    <= bus.cpu_we;
              re_reg    <= ~bus.cpu_we;
              state_reg <= ACCESS;
            end else begin
              // No such slave: finish at once with an error and no strobe.
              rdata_reg <= 32'h0;
              err_reg   <= 1'b1;
              state_reg <= DONE;
            end
          end
        end

        ACCESS: begin
`ifdef BUS_BRIDGE_TIMEOUT_EN
          tmo_cnt_reg <= 8'd0;
`endif
          state_reg <= WAIT;
        end

        WAIT: begin
          // Ack is tested first so an ack coinciding with the timeout wins.
          if (ack_hit) begin
            sel_reg   <= 16'h0000;
            rdata_reg <= write_reg ? 32'h0 : rdata_slice[mod_reg];
            state_reg <= DONE;
          end
`ifdef BUS_BRIDGE_TIMEOUT_EN
          else if (tmo_cnt_reg == TMO_LAST) begin
            sel_reg   <= 16'h0000;
            rdata_reg <= 32'hDEADBEEF;
            err_reg   <= 1'b1;
            state_reg <= DONE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 8'd1;
          end
`endif
        end

        DONE: begin
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Stall is combinational in IDLE so the CPU holds from the request cycle.
  assign bus.cpu_stall = (state_reg == ACCESS) || (state_reg == WAIT) ||
                         ((state_reg == IDLE) && req);

  assign bus.cpu_rdata = rdata_reg;
  assign bus.bus_err   = err_reg;
  assign bus.slv_sel   = sel_reg;
  assign bus.slv_addr  = addr_reg;
  assign bus.slv_wdata = wdata_reg;
  assign bus.slv_re    = re_reg;
  assign bus.slv_we    = we_reg;

endmodule

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 Parameter: TIMEOUT, default 255, number of WAIT cycles before a transaction is aborted (range 1-255).
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: rst  in  1  asynchronous, active-low reset.
REQ-004 Port: mod  in  8  target module number from the address decoder (0-13 valid).
REQ-005 Port: eff_addr  in  32  module-relative effective address from the address decoder.
REQ-006 Port: cpu_re, cpu_we  in  1 each  CPU read / write request, held until cpu_stall is low.
REQ-007 Port: cpu_wdata  in  32  CPU write data.
REQ-008 Port: cpu_rdata  out  32  read data, valid in the DONE cycle.
REQ-009 Port: cpu_stall  out  1  CPU must hold its request while high.
REQ-010 Port: bus_err  out  1  one-cycle pulse marking an aborted or invalid transaction.
REQ-011 Port: slv_sel  out  16  one-hot slave select, bit n = module n.
REQ-012 Port: slv_addr, slv_wdata  out  32 each  registered address and write data to slaves.
REQ-013 Port: slv_re, slv_we  out  1 each  single-cycle read/write strobes.
REQ-014 Port: slv_ack  in  16  per-slave completion, bit n from module n.
REQ-015 Port: slv_rdata  in  512  flattened read data; module n occupies bits [32n+31:32n].

Function
REQ-016 FSM states: IDLE, ACCESS, WAIT, DONE.
REQ-017 IDLE: on cpu_re or cpu_we, latch mod, eff_addr, cpu_wdata and direction; next state ACCESS.
REQ-018 cpu_we and cpu_re both high: write only.
REQ-019 cpu_stall = 1 in ACCESS and WAIT, and combinationally in IDLE whenever a request is present; 0 in DONE and in an idle IDLE.
REQ-020 ACCESS: slv_sel one-hot of the latched mod; slv_re or slv_we high for exactly this cycle; next state WAIT.
REQ-021 WAIT: slv_sel held, strobes low; when slv_ack[latched mod] is high, capture that slave's slv_rdata slice and go to DONE.
REQ-022 Acks from non-selected slaves are ignored.
REQ-023 DONE: slv_sel = 0; cpu_rdata holds the captured data (0 for writes); next state IDLE unconditionally.
REQ-024 Minimum latency: request in cycle 0, ack in cycle 2, DONE in cycle 3; the CPU is stalled for 3 cycles.
REQ-025 Latched mod > 13 (invalid): skip ACCESS and WAIT, go directly to DONE with cpu_rdata = 0 and bus_err = 1; no slave strobe is issued.
REQ-026 slv_addr and slv_wdata stay stable from ACCESS through WAIT.
REQ-027 cpu_rdata keeps its last value outside DONE.

Reset
REQ-028 rst low forces, asynchronously: state = IDLE, slv_sel = 0, slv_re = slv_we = 0, slv_addr = slv_wdata = 0, cpu_rdata = 0, bus_err = 0, timeout counter = 0.
REQ-029 Reset mid-transaction abandons it: no ack is awaited after release, and the CPU must reissue the request.

Configuration
REQ-030 Macro BUS_BRIDGE_TIMEOUT_EN defined: an 8-bit counter clears on entry to WAIT and increments each WAIT cycle without an ack.
REQ-031 With BUS_BRIDGE_TIMEOUT_EN, when the counter reaches TIMEOUT: go to DONE with cpu_rdata = 32'hDEADBEEF and bus_err = 1.
REQ-032 With BUS_BRIDGE_TIMEOUT_EN, an ack arriving in the same cycle as the timeout wins: normal completion, bus_err = 0.
REQ-033 BUS_BRIDGE_TIMEOUT_EN undefined: no counter; WAIT persists until ack; bus_err pulses only for an invalid mod.

Verification
REQ-034 Read, mod=1, eff_addr=0x000010, slv_ack[1] in first WAIT cycle, slice1 = 0x12345678 -> slv_sel = 0x0002; slv_re pulses once; stall high 3 cycles; cpu_rdata = 0x12345678 in DONE.
REQ-035 Write, mod=4, wdata=0xA5, ack after 5 WAIT cycles -> slv_we pulses once; slv_wdata = 0xA5 held through WAIT; stall high 8 cycles; bus_err = 0.
REQ-036 Read, mod=20 -> no slv_sel bit set; DONE in cycle 1; cpu_rdata = 0; bus_err = 1 for one cycle.
REQ-037 TIMEOUT=4, timeout macro on, no ack -> DONE after 4 WAIT cycles; cpu_rdata = 0xDEADBEEF; bus_err = 1.
REQ-038 slv_ack[3] asserted while mod=2 is selected -> ignored; the FSM stays in WAIT until slv_ack[2].
REQ-039 rst low during WAIT -> all outputs zero immediately; after release, state IDLE and the stale ack is ignored.
